// File: rtl/inst_fetch.sv
// inst_fetch: instruction-memory initiator with wait-state handshake, prefetch FIFO,
// decode-stall backpressure and branch redirect that drops stale in-flight fetches.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_ce_o,
    output logic [31:0] inst_addr_o,
    input  logic [31:0] inst_data_i,
    input  logic        inst_ready_i,
    input  logic        id_stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        if_valid_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {FETCH, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d, tgt_q, tgt_d;
    logic [AW:0] count_q, count_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [31:0] pc_mem_q [FIFO_DEPTH];
    logic [31:0] pc_mem_d [FIFO_DEPTH];
    logic [31:0] inst_mem_q [FIFO_DEPTH];
    logic [31:0] inst_mem_d [FIFO_DEPTH];
    logic        pop, push;
    logic [31:0] target;

    assign target = {branch_target_i[31:2], 2'b00};

    always_comb begin
        if_valid_o  = (count_q != '0) && !branch_flag_i;
        if_pc_o     = pc_mem_q[rd_q];
        if_inst_o   = inst_mem_q[rd_q];
        pop         = if_valid_o && !id_stall_i;
        // ce is held through DISCARD; in FETCH a slot must be free counting this cycle's pop
        inst_ce_o   = rst && (state_q == DISCARD || count_q != FULL || pop);
        inst_addr_o = fpc_q;
        push        = inst_ce_o && inst_ready_i && state_q == FETCH && !branch_flag_i;
        state_d     = state_q;
        fpc_d       = fpc_q;
        tgt_d       = tgt_q;
        count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
        rd_d        = rd_q + AW'(pop);
        wr_d        = wr_q + AW'(push);
        pc_mem_d    = pc_mem_q;
        inst_mem_d  = inst_mem_q;
        if (push) begin
            pc_mem_d[wr_q]   = fpc_q;
            inst_mem_d[wr_q] = inst_data_i;
            fpc_d            = fpc_q + 32'd4;
        end
        if (branch_flag_i) begin
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
            tgt_d   = target;
            if (inst_ce_o && !inst_ready_i) begin
                state_d = DISCARD;
            end else begin
                state_d = FETCH;
                fpc_d   = target;
            end
        end else if (state_q == DISCARD && inst_ready_i) begin
            state_d = FETCH;
            fpc_d   = tgt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            fpc_q      <= RESET_PC;
            tgt_q      <= RESET_PC;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            pc_mem_q   <= '{default: '0};
            inst_mem_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            tgt_q      <= tgt_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized and directed checks of inst_fetch against an in-order
// instruction-stream model (sequential pcs, restarting at each branch target).
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_ce_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_data_i;
    logic        inst_ready_i = 1'b0;
    logic        id_stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        if_valid_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;

    int n_checks = 0;
    int n_fail = 0;

    logic        o_ce, o_valid, o_pop, o_rdy;
    logic [31:0] o_addr, o_pc, o_inst, e_pc, e_inst, exp_pc;
    int          waited = 0;
    int          mem_wait = 0;
    bit          mem_rand = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    assign inst_data_i = word(inst_addr_o);

    inst_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .inst_ce_o(inst_ce_o), .inst_addr_o(inst_addr_o),
        .inst_data_i(inst_data_i), .inst_ready_i(inst_ready_i),
        .id_stall_i(id_stall_i), .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .if_valid_o(if_valid_o), .if_inst_o(if_inst_o), .if_pc_o(if_pc_o)
    );

    // One clock: drive inputs, sample outputs, advance the stream model and memory wait counter.
    task automatic cycle(input logic stall, input logic br, input logic [31:0] tgt);
        @(negedge clk);
        id_stall_i      = stall;
        branch_flag_i   = br;
        branch_target_i = tgt;
        inst_ready_i    = (waited >= mem_wait);
        #1;
        o_ce = inst_ce_o; o_addr = inst_addr_o; o_rdy = inst_ready_i;
        o_valid = if_valid_o; o_pc = if_pc_o; o_inst = if_inst_o;
        o_pop = o_valid && !stall;
        if (o_pop) begin
            e_pc   = exp_pc;
            e_inst = word(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        if (br) exp_pc = {tgt[31:2], 2'b00};
        @(posedge clk);
        if (o_ce && o_rdy) begin
            waited = 0;
            if (mem_rand) mem_wait = $urandom_range(0, 3);
        end else if (o_ce) waited++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; id_stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0; inst_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        exp_pc = 32'h0;
        waited = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++; if (inst_ce_o !== 1'b0) begin n_fail++; $display("FAIL rst_ce: got %b want 0", inst_ce_o); end
        n_checks++; if (inst_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", inst_addr_o); end
        n_checks++; if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid_o); end
        n_checks++; if (if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin n_fail++; $display("FAIL rst_head: got pc %h inst %h want 0", if_pc_o, if_inst_o); end
        @(posedge clk);
        #1 rst = 1'b1;
        exp_pc = 32'h0; waited = 0; mem_wait = 0;
        cycle(1'b0, 1'b0, 32'h0);
        n_checks++; if (o_ce !== 1'b1 || o_addr !== 32'h0) begin n_fail++; $display("FAIL rst_first_req: got ce %b addr %h want 1 0", o_ce, o_addr); end
    endtask

    task automatic test_zero_wait();
        int pops = 0;
        mem_wait = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            n_checks++; if (o_ce !== 1'b1 || o_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL zw_req: cycle %0d got ce %b addr %h want 1 %h", i, o_ce, o_addr, 32'(i * 4)); end
            n_checks++; if (o_valid !== logic'(i > 0)) begin n_fail++; $display("FAIL zw_valid: cycle %0d got %b", i, o_valid); end
            if (o_pop) begin
                pops++;
                n_checks++; if (o_pc !== e_pc || o_inst !== e_inst) begin n_fail++; $display("FAIL zw_stream: got %h/%h want %h/%h", o_pc, o_inst, e_pc, e_inst); end
                n_checks++; if (o_pc !== 32'((i - 1) * 4)) begin n_fail++; $display("FAIL zw_pc: got %h want %h", o_pc, 32'((i - 1) * 4)); end
            end
        end
        n_checks++; if (pops !== 9) begin n_fail++; $display("FAIL zw_count: got %0d want 9", pops); end
    endtask

    task automatic test_stall();
        int pops = 0;
        logic stall;
        mem_wait = 0;
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            stall = (i >= 3 && i < 8);
            cycle(stall, 1'b0, 32'h0);
            if (i == 3) begin
                n_checks++; if (o_pc !== 32'h8) begin n_fail++; $display("FAIL st_head: got %h want 8", o_pc); end
            end
            if (i >= 4 && i < 8) begin
                n_checks++; if (o_ce !== 1'b0) begin n_fail++; $display("FAIL st_ce: cycle %0d got %b want 0", i, o_ce); end
                n_checks++; if (o_valid !== 1'b1 || o_pc !== 32'h8) begin n_fail++; $display("FAIL st_hold: cycle %0d got %b %h want 1 8", i, o_valid, o_pc); end
            end
            if (o_pop) begin
                pops++;
                n_checks++; if (o_pc !== e_pc || o_inst !== e_inst) begin n_fail++; $display("FAIL st_stream: got %h/%h want %h/%h", o_pc, o_inst, e_pc, e_inst); end
            end
        end
        n_checks++; if (pops !== 8) begin n_fail++; $display("FAIL st_count: got %0d want 8", pops); end
    endtask

    task automatic test_wait_states();
        int pops = 0;
        mem_wait = 2;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            n_checks++; if (o_ce !== 1'b1 || o_addr !== 32'((i / 3) * 4)) begin n_fail++; $display("FAIL ws_addr: cycle %0d got %b %h want 1 %h", i, o_ce, o_addr, 32'((i / 3) * 4)); end
            n_checks++; if (o_valid !== logic'(i > 0 && i % 3 == 0)) begin n_fail++; $display("FAIL ws_valid: cycle %0d got %b", i, o_valid); end
            if (o_pop) begin
                pops++;
                n_checks++; if (o_pc !== e_pc || o_inst !== e_inst) begin n_fail++; $display("FAIL ws_stream: got %h/%h want %h/%h", o_pc, o_inst, e_pc, e_inst); end
            end
        end
        n_checks++; if (pops !== 3) begin n_fail++; $display("FAIL ws_count: got %0d want 3", pops); end
    endtask

    task automatic test_branch_discard();
        bit got = 1'b0;
        mem_wait = 2;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(logic'(i == 6), logic'(i == 7), 32'h100);
            if (i == 6) begin
                n_checks++; if (o_valid !== 1'b1 || o_pc !== 32'h4) begin n_fail++; $display("FAIL bd_pre: got %b %h want 1 4", o_valid, o_pc); end
            end
            if (i == 7) begin
                n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bd_mask: got %b want 0", o_valid); end
            end
            if (i == 8) begin
                n_checks++; if (o_ce !== 1'b1 || o_addr !== 32'h8) begin n_fail++; $display("FAIL bd_hold: got %b %h want 1 8", o_ce, o_addr); end
                n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bd_flush: got %b want 0", o_valid); end
            end
            if (i == 9) begin
                n_checks++; if (o_ce !== 1'b1 || o_addr !== 32'h100) begin n_fail++; $display("FAIL bd_target: got %b %h want 1 100", o_ce, o_addr); end
            end
            if (o_pop) begin
                n_checks++; if (o_pc !== e_pc || o_inst !== e_inst) begin n_fail++; $display("FAIL bd_stream: got %h/%h want %h/%h", o_pc, o_inst, e_pc, e_inst); end
                if (i > 7 && !got) begin
                    got = 1'b1;
                    n_checks++; if (o_pc !== 32'h100) begin n_fail++; $display("FAIL bd_first: got %h want 100", o_pc); end
                end
            end
        end
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL bd_timeout: got no instruction after branch"); end
    endtask

    task automatic test_branch_ready();
        logic        br;
        logic [31:0] tgt;
        mem_wait = 0;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            br  = (i == 3 || i == 6);
            tgt = (i == 3) ? 32'h203 : 32'hFFFF_FFFC;
            cycle(1'b0, br, tgt);
            if (i == 3) begin
                n_checks++; if (o_valid !== 1'b0 || o_addr !== 32'hC || o_rdy !== 1'b1) begin n_fail++; $display("FAIL br_cycle: got valid %b addr %h", o_valid, o_addr); end
            end
            if (i == 4) begin
                n_checks++; if (o_ce !== 1'b1 || o_addr !== 32'h200) begin n_fail++; $display("FAIL br_target: got %b %h want 1 200", o_ce, o_addr); end
            end
            if (i == 7) begin
                n_checks++; if (o_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL br_top: got %h want fffffffc", o_addr); end
            end
            if (i == 8) begin
                n_checks++; if (o_addr !== 32'h0) begin n_fail++; $display("FAIL br_wrap_addr: got %h want 0", o_addr); end
                n_checks++; if (o_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL br_wrap_pc_hi: got %h want fffffffc", o_pc); end
            end
            if (i == 9) begin
                n_checks++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL br_wrap_pc_lo: got %h want 0", o_pc); end
            end
            if (o_pop) begin
                n_checks++; if (o_pc !== e_pc || o_inst !== e_inst) begin n_fail++; $display("FAIL br_stream: got %h/%h want %h/%h", o_pc, o_inst, e_pc, e_inst); end
            end
        end
    endtask

    task automatic test_reset_discard();
        int pops = 0;
        mem_wait = 0;
        apply_reset();
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        mem_wait = 3;
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h400);
        @(negedge clk);
        id_stall_i = 1'b0; branch_flag_i = 1'b0; inst_ready_i = 1'b0;
        #1;
        n_checks++; if (inst_ce_o !== 1'b1 || inst_addr_o !== 32'hC) begin n_fail++; $display("FAIL rd_discard: got %b %h want 1 c", inst_ce_o, inst_addr_o); end
        #1 rst = 1'b0;
        #1;
        n_checks++; if (inst_ce_o !== 1'b0 || inst_addr_o !== 32'h0) begin n_fail++; $display("FAIL rd_req: got %b %h want 0 0", inst_ce_o, inst_addr_o); end
        n_checks++; if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin n_fail++; $display("FAIL rd_out: got %b %h %h want 0 0 0", if_valid_o, if_pc_o, if_inst_o); end
        @(posedge clk);
        #1 rst = 1'b1;
        exp_pc = 32'h0; waited = 0; mem_wait = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (i == 0) begin
                n_checks++; if (o_ce !== 1'b1 || o_addr !== 32'h0) begin n_fail++; $display("FAIL rd_first: got %b %h want 1 0", o_ce, o_addr); end
            end
            if (o_pop) begin
                pops++;
                n_checks++; if (o_pc !== e_pc || o_inst !== e_inst) begin n_fail++; $display("FAIL rd_stream: got %h/%h want %h/%h", o_pc, o_inst, e_pc, e_inst); end
            end
        end
        n_checks++; if (pops !== 4) begin n_fail++; $display("FAIL rd_count: got %0d want 4", pops); end
    endtask

    task automatic test_random();
        int          pops = 0;
        logic        stall, br, prev_pend;
        logic [31:0] tgt, prev_addr;
        prev_pend = 1'b0;
        prev_addr = '0;
        mem_rand = 1'b1;
        mem_wait = 1;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            stall = ($urandom_range(0, 9) < 3);
            br    = ($urandom_range(0, 19) == 0);
            tgt   = $urandom;
            cycle(stall, br, tgt);
            if (prev_pend) begin
                n_checks++; if (o_ce !== 1'b1 || o_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_protocol: cycle %0d got %b %h want 1 %h", i, o_ce, o_addr, prev_addr); end
            end
            if (br) begin
                n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_mask: cycle %0d got %b want 0", i, o_valid); end
            end
            if (o_pop) begin
                pops++;
                n_checks++; if (o_pc !== e_pc || o_inst !== e_inst) begin n_fail++; $display("FAIL rnd_stream: cycle %0d got %h/%h want %h/%h", i, o_pc, o_inst, e_pc, e_inst); end
            end
            prev_pend = o_ce && !o_rdy;
            prev_addr = o_addr;
        end
        mem_rand = 1'b0;
        n_checks++; if (pops < 150) begin n_fail++; $display("FAIL rnd_progress: got %0d instructions want >= 150", pops); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_wait_states();
        test_branch_discard();
        test_branch_ready();
        test_reset_discard();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit: the initiator side of the instruction-memory port. Generates `ce`/address requests toward the instruction ROM, accepts memory that responds with zero or more wait cycles, and buffers fetched words in a small prefetch FIFO feeding the IF/ID stage. Handles decode-stage stalls and branch redirects from the execute stage, discarding any in-flight request that a redirect makes stale.

## Interface
- `RESET_PC`, 32'h00000000, first fetch address after reset (bits [1:0] must be 0)
- `FIFO_DEPTH`, 2, prefetch buffer entries (power of 2, ≥2)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `inst_ce_o`  out  1  fetch request / memory chip enable
- `inst_addr_o`  out  32  byte address of requested word
- `inst_data_i`  in  32  returned instruction word
- `inst_ready_i`  in  1  memory completes the current request this cycle
- `id_stall_i`  in  1  decode stage cannot accept an instruction
- `branch_flag_i`  in  1  redirect fetch this cycle
- `branch_target_i`  in  32  redirect address (bits [1:0] ignored, treated as 00)
- `if_valid_o`  out  1  `if_inst_o`/`if_pc_o` hold a valid instruction
- `if_inst_o`  out  32  instruction at FIFO head
- `if_pc_o`  out  32  address of instruction at FIFO head

## Operation
- Memory protocol: request = `inst_ce_o`=1 with `inst_addr_o`. Once asserted, `ce` and address stay stable until the cycle `inst_ready_i`=1; `inst_data_i` is sampled on that rising edge. `inst_ready_i` is ignored when `ce`=0. At most one request outstanding.
- Fetch PC register `fpc`: increments by 4 on each completed non-discarded request; wraps 0xFFFFFFFC → 0x00000000.
- New request is started only when a FIFO slot is free counting a same-cycle pop: `count - pop < FIFO_DEPTH`.
- FIFO entry = {pc, inst}. Push on completed, non-discarded request. Pop when `if_valid_o`=1 and `id_stall_i`=0. Push and pop in the same cycle allowed (count unchanged), including when full.
- `if_valid_o` = FIFO non-empty AND `branch_flag_i`=0 (combinational mask).
- FSM states:
  - FETCH: normal; `ce` driven per slot rule, `addr`=`fpc`.
  - DISCARD: a stale request is in flight; hold `ce`=1 and old address until `inst_ready_i`=1, drop the data, then → FETCH with `fpc`=target.
- Branch (`branch_flag_i`=1), any state: FIFO flushed (count→0, no pop, no push that cycle); `fpc`←{target[31:2],2'b00}.
  - No request in flight, or in-flight request completes this cycle: data dropped, stay/return to FETCH, next cycle requests target.
  - Request in flight and `inst_ready_i`=0: → DISCARD (target latched).
  - Branch while in DISCARD: target replaced by newest; stay in DISCARD unless ready this cycle.

## Timing
- Reset values: `inst_ce_o`=0, `inst_addr_o`=`RESET_PC`, `if_valid_o`=0, `if_inst_o`=0, `if_pc_o`=0, FIFO empty, state FETCH, `fpc`=`RESET_PC`.
- First cycle after reset release: `ce`=1, `addr`=`RESET_PC`.
- Latency: request completing at edge N → `if_valid_o`=1 in cycle N+1 (registered FIFO output).
- Zero-wait memory, no stall: one instruction per cycle sustained; `ce` continuously high.
- k wait cycles per access: one instruction per k+1 cycles.
- Branch at edge N: target requested in cycle N+1 (no in-flight conflict) or the cycle after the discarded request's ready edge.
- Reset mid-request or mid-DISCARD: immediate return to reset values; no data retained.

## Test plan
- Zero-wait memory, `RESET_PC`=0, no stall → `ce` high from cycle 1; `if_pc_o` = 0,4,8,12 on consecutive cycles, `if_inst_o` matches memory words.
- `id_stall_i`=1 for 5 cycles with ready=1 → FIFO fills to 2 then `ce`=0; head stays at same pc; on release, pcs continue without gap or duplicate.
- Memory with 2 wait cycles → `addr` stable 3 cycles per request; valid instructions every 3 cycles, pcs 0,4,8.
- Branch to 0x100 while request for 0x08 waits (ready low) → DISCARD; 0x08 data dropped on ready; next request addr 0x100; first `if_pc_o` after branch = 0x100; `if_valid_o`=0 during branch cycle.
- Branch target 0x203 with ready=1 same cycle → fetched data dropped, next addr 0x200; `fpc` at 0xFFFFFFFC wraps next request to 0x00000000.
- Assert `rst`=0 mid-DISCARD → all outputs at reset values asynchronously; after release, first request addr = `RESET_PC`.
